char_write_ctrl: RTL and testbench

Write sequencer for the text-mode character row buffers. Accepts a character/command stream from the host-side (Arduino) interface over a valid/ready handshake and tracks a text cursor. Issues one-hot row write strobes with column address and character code, only while the VGA timing reports blanking, so writes never collide with display reads. Sits between the host command decoder and the bank of NUM_ROWS character row buffers.

---
 rtl/char_ctrl_pkg.sv | 28 ++
 rtl/char_write_ctrl_if.sv | 23 ++
 rtl/char_cursor.sv | 61 ++++++
 rtl/char_write_ctrl.sv | 150 +++++++++++++++
 tb/tb_char_write_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/char_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : char_ctrl_pkg
// Purpose : Shared types and constants for the character write sequencer:
//           FSM state encoding, host command codes and the default code
//           written by clear-screen.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package char_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PEND  = 2'd1,
      ST_WRITE = 2'd2,
      ST_CLEAR = 2'd3
   } state_t;

   // Command codes carried in in_char[1:0] when in_ctrl = 1
   localparam logic [1:0] CMD_NEWLINE = 2'b00;
   localparam logic [1:0] CMD_HOME    = 2'b01;
   localparam logic [1:0] CMD_CLEAR   = 2'b10;
   localparam logic [1:0] CMD_NOP     = 2'b11;

   localparam logic [5:0] BLANK_CHAR_DEFAULT = 6'h3F;

endpackage : char_ctrl_pkg
`default_nettype wire

// File: rtl/char_write_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : char_write_ctrl_if
// Purpose : Host-side character/command stream with valid/ready handshake.
// Signals : in_char  - character code, or command in [1:0] when in_ctrl=1
//           in_ctrl  - 1 = command, 0 = printable character
//           in_valid - host has a character/command
//           in_ready - sequencer can accept (transfer on valid & ready)
// Modports: master (host side), slave (sequencer side)
// Revision: 1.0 - initial release
// ============================================================================
interface char_write_ctrl_if #(
   parameter int CHAR_W = 6
);
   logic [CHAR_W-1:0] in_char;
   logic              in_ctrl;
   logic              in_valid;
   logic              in_ready;

   modport master (output in_char, output in_ctrl, output in_valid, input  in_ready);
   modport slave  (input  in_char, input  in_ctrl, input  in_valid, output in_ready);
endinterface : char_write_ctrl_if
`default_nettype wire

// File: rtl/char_cursor.sv
`default_nettype none
// ============================================================================
// Module  : char_cursor
// Purpose : Text cursor row/column counters. Supports advance, newline and
//           home. Rows always wrap NUM_ROWS-1 -> 0 (no scrolling).
//           Build option CHAR_CTRL_AUTOWRAP_EN: advancing past the last
//           column wraps to column 0 of the next row; otherwise the column
//           saturates at COLS-1.
// Ports   : clk, rst_n (async active-low), advance, newline, home,
//           row, col (current cursor position)
// Revision: 1.0 - initial release
// ============================================================================
module char_cursor #(
   parameter int NUM_ROWS = 8,
   parameter int COLS     = 32
) (
   input  wire                         clk,
   input  wire                         rst_n,
   input  wire                         advance,
   input  wire                         newline,
   input  wire                         home,
   output logic [$clog2(NUM_ROWS)-1:0] row,
   output logic [$clog2(COLS)-1:0]     col
);
   localparam int RW = $clog2(NUM_ROWS);
   localparam int CW = $clog2(COLS);
   localparam logic [RW-1:0] LAST_ROW = RW'(NUM_ROWS - 1);
   localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

   logic [RW-1:0] row_next;

   assign row_next = (row == LAST_ROW) ? '0 : row + RW'(1);

   // home has priority over newline, newline over advance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row <= '0;
         col <= '0;
      end else if (home) begin
         row <= '0;
         col <= '0;
      end else if (newline) begin
         row <= row_next;
         col <= '0;
      end else if (advance) begin
         if (col == LAST_COL) begin
`ifdef CHAR_CTRL_AUTOWRAP_EN
            row <= row_next;
            col <= '0;
`else
            // saturate: later characters overwrite the last column
            col <= LAST_COL;
`endif
         end else begin
            col <= col + CW'(1);
         end
      end
   end

endmodule : char_cursor
`default_nettype wire

// File: rtl/char_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : char_write_ctrl
// Purpose : Write sequencer for the text-mode character row buffers. Accepts
//           characters/commands from the host, tracks a cursor and issues
//           row write strobes only while the VGA timing reports blanking.
//           Build option CHAR_CTRL_AUTOWRAP_EN selects column autowrap in the
//           cursor (see char_cursor).
// Ports   : clk, rst_n      - clock, async active-low reset
//           host           - char/command stream (char_write_ctrl_if.slave)
//           blank          - display blanking, writes permitted when high
//           wr_row_en      - one-hot row strobe (all ones during clear)
//           wr_col/wr_char - column address and code of the write
//           cursor_row/col - current cursor position
//           busy           - high in any state other than IDLE
// Revision: 1.0 - initial release
// ============================================================================
module char_write_ctrl
   import char_ctrl_pkg::*;
#(
   parameter int                NUM_ROWS   = 8,
   parameter int                COLS       = 32,
   parameter int                CHAR_W     = 6,
   parameter logic [CHAR_W-1:0] BLANK_CHAR = CHAR_W'(BLANK_CHAR_DEFAULT)
) (
   input  wire                         clk,
   input  wire                         rst_n,
   char_write_ctrl_if.slave            host,
   input  wire                         blank,
   output logic [NUM_ROWS-1:0]         wr_row_en,
   output logic [$clog2(COLS)-1:0]     wr_col,
   output logic [CHAR_W-1:0]           wr_char,
   output logic [$clog2(NUM_ROWS)-1:0] cursor_row,
   output logic [$clog2(COLS)-1:0]     cursor_col,
   output logic                        busy
);
   localparam int CW = $clog2(COLS);
   localparam logic [CW-1:0]       LAST_COL = CW'(COLS - 1);
   localparam logic [NUM_ROWS-1:0] ROW_ONE  = {{(NUM_ROWS-1){1'b0}}, 1'b1};

   state_t              state_q, state_d;
   logic [CHAR_W-1:0]   held_q, held_d;
   logic [CW-1:0]       sweep_q, sweep_d;
   logic [NUM_ROWS-1:0] row_en_d;
   logic [CW-1:0]       col_d;
   logic [CHAR_W-1:0]   char_d;
   logic                cur_adv, cur_nl, cur_home;

   char_cursor #(
      .NUM_ROWS (NUM_ROWS),
      .COLS     (COLS)
   ) u_cursor (
      .clk     (clk),
      .rst_n   (rst_n),
      .advance (cur_adv),
      .newline (cur_nl),
      .home    (cur_home),
      .row     (cursor_row),
      .col     (cursor_col)
   );

   assign host.in_ready = (state_q == ST_IDLE);
   assign busy          = (state_q != ST_IDLE);

   // Write-port outputs are registered: the strobe is loaded on the edge
   // that closes a blank-high cycle, so it is visible in the following cycle.
   always_comb begin
      state_d  = state_q;
      held_d   = held_q;
      sweep_d  = sweep_q;
      row_en_d = '0;
      col_d    = wr_col;
      char_d   = wr_char;
      cur_adv  = 1'b0;
      cur_nl   = 1'b0;
      cur_home = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (host.in_valid) begin
               if (!host.in_ctrl) begin
                  held_d  = host.in_char;
                  state_d = ST_PEND;
               end else begin
                  case (host.in_char[1:0])
                     CMD_NEWLINE: cur_nl   = 1'b1;
                     CMD_HOME:    cur_home = 1'b1;
                     CMD_CLEAR: begin
                        sweep_d = '0;
                        state_d = ST_CLEAR;
                     end
                     default: ;  // CMD_NOP: accepted and dropped
                  endcase
               end
            end
         end

         ST_PEND: begin
            if (blank) begin
               state_d  = ST_WRITE;
               row_en_d = ROW_ONE << cursor_row;
               col_d    = cursor_col;
               char_d   = held_q;
            end
         end

         ST_WRITE: begin
            // strobe is already committed; blank no longer matters here
            cur_adv = 1'b1;
            state_d = ST_IDLE;
         end

         ST_CLEAR: begin
            if (blank) begin
               row_en_d = '1;
               col_d    = sweep_q;
               char_d   = BLANK_CHAR;
               if (sweep_q == LAST_COL) begin
                  cur_home = 1'b1;
                  state_d  = ST_IDLE;
               end else begin
                  sweep_d = sweep_q + CW'(1);
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         held_q    <= '0;
         sweep_q   <= '0;
         wr_row_en <= '0;
         wr_col    <= '0;
         wr_char   <= '0;
      end else begin
         state_q   <= state_d;
         held_q    <= held_d;
         sweep_q   <= sweep_d;
         wr_row_en <= row_en_d;
         wr_col    <= col_d;
         wr_char   <= char_d;
      end
   end

endmodule : char_write_ctrl
`default_nettype wire

// File: tb/tb_char_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_char_write_ctrl
// Purpose : Self-checking bench for char_write_ctrl (default parameters).
//           Expected writes are queued by the stimulus; a monitor pops and
//           compares every cycle the DUT presents a row strobe.
//           Honours CHAR_CTRL_AUTOWRAP_EN for cursor expectations.
// Revision: 1.0 - initial release
// ============================================================================
module tb_char_write_ctrl;

   typedef struct packed {
      logic [7:0] en;
      logic [4:0] col;
      logic [5:0] ch;
   } wr_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       blank;
   logic [7:0] wr_row_en;
   logic [4:0] wr_col;
   logic [5:0] wr_char;
   logic [2:0] cursor_row;
   logic [4:0] cursor_col;
   logic       busy;
   logic       last_blank;

   int  checks = 0;
   int  errors = 0;
   wr_t exp_q[$];

   char_write_ctrl_if #(.CHAR_W(6)) bus ();

   char_write_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .host       (bus),
      .blank      (blank),
      .wr_row_en  (wr_row_en),
      .wr_col     (wr_col),
      .wr_char    (wr_char),
      .cursor_row (cursor_row),
      .cursor_col (cursor_col),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // blank as seen by the DUT at the most recent rising edge
   always @(posedge clk) last_blank <= blank;

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (rst_n && wr_row_en != 8'h00) begin
         wr_t e;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_strobe: got en=%h col=%0d ch=%h, expected no write",
                     wr_row_en, wr_col, wr_char);
         end else begin
            e = exp_q.pop_front();
            if (wr_row_en !== e.en || wr_col !== e.col || wr_char !== e.ch) begin
               errors++;
               $display("FAIL write: got en=%h col=%0d ch=%h, expected en=%h col=%0d ch=%h",
                        wr_row_en, wr_col, wr_char, e.en, e.col, e.ch);
            end
         end
         checks++;
         if (last_blank !== 1'b1) begin
            errors++;
            $display("FAIL strobe_blank: strobe issued from blank=%b cycle, expected 1", last_blank);
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] en, input logic [4:0] col, input logic [5:0] ch);
      wr_t e;
      e.en = en; e.col = col; e.ch = ch;
      exp_q.push_back(e);
   endtask

   // Present one item; returns #1 after the transfer edge
   task automatic send(input logic ctrl, input logic [5:0] code);
      int n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         chk("send_timeout", 0, 1);
      end else begin
         bus.in_ctrl  = ctrl;
         bus.in_char  = code;
         bus.in_valid = 1'b1;
         @(posedge clk);
         #1 bus.in_valid = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", int'(busy), 0);
   endtask

   initial begin
      int cnt;
      rst_n        = 1'b0;
      blank        = 1'b0;
      bus.in_char  = '0;
      bus.in_ctrl  = 1'b0;
      bus.in_valid = 1'b0;

      // ---- reset values
      repeat (3) @(negedge clk);
      chk("rst_in_ready", int'(bus.in_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_wr_row_en", int'(wr_row_en), 0);
      chk("rst_wr_col", int'(wr_col), 0);
      chk("rst_wr_char", int'(wr_char), 0);
      chk("rst_cursor", int'({cursor_row, cursor_col}), 0);
      rst_n = 1'b1;

      // ---- single character with blank high: strobe two cycles after transfer
      blank = 1'b1;
      push(8'h01, 5'd0, 6'h0A);
      send(1'b0, 6'h0A);
      @(negedge clk);
      chk("pend_in_ready", int'(bus.in_ready), 0);
      @(negedge clk);
      chk("strobe_timing", int'(wr_row_en), 8'h01);
      @(negedge clk);
      chk("ready_after_write", int'(bus.in_ready), 1);
      chk("cursor_col_after_A", int'(cursor_col), 1);

      // ---- character held in PEND while blank is low
      blank = 1'b0;
      push(8'h01, 5'd1, 6'h05);
      send(1'b0, 6'h05);
      repeat (5) @(negedge clk);
      chk("held_in_ready", int'(bus.in_ready), 0);
      chk("held_no_strobe", int'(wr_row_en), 0);
      blank = 1'b1;
      @(negedge clk);
      chk("strobe_after_blank", int'(wr_row_en), 8'h01);
      @(negedge clk);
      chk("ready_after_held", int'(bus.in_ready), 1);
      chk("cursor_col_2", int'(cursor_col), 2);

      // ---- 33 characters from home: end-of-row behaviour
      send(1'b1, 6'd1);
      for (int i = 0; i < 33; i++) begin
`ifdef CHAR_CTRL_AUTOWRAP_EN
         if (i < 32) push(8'h01, 5'(i), 6'(i + 1));
         else        push(8'h02, 5'd0, 6'(i + 1));
`else
         if (i < 32) push(8'h01, 5'(i), 6'(i + 1));
         else        push(8'h01, 5'd31, 6'(i + 1));
`endif
         send(1'b0, 6'(i + 1));
      end
      wait_idle();
`ifdef CHAR_CTRL_AUTOWRAP_EN
      chk("wrap_cursor_row", int'(cursor_row), 1);
      chk("wrap_cursor_col", int'(cursor_col), 1);
`else
      chk("sat_cursor_row", int'(cursor_row), 0);
      chk("sat_cursor_col", int'(cursor_col), 31);
`endif

      // ---- newline at row 7 wraps to row 0
      send(1'b1, 6'd1);
      repeat (7) send(1'b1, 6'd0);
      @(negedge clk);
      chk("row7", int'(cursor_row), 7);
      push(8'h80, 5'd0, 6'h11);
      send(1'b0, 6'h11);
      send(1'b1, 6'd0);
      @(negedge clk);
      chk("nl_in_ready", int'(bus.in_ready), 1);
      chk("nl_wrap_row", int'(cursor_row), 0);
      chk("nl_wrap_col", int'(cursor_col), 0);

      // ---- no-op command: accepted, nothing changes
      send(1'b1, 6'd3);
      @(negedge clk);
      chk("nop_busy", int'(busy), 0);

      // ---- clear screen with blank toggling every 4 cycles
      send(1'b1, 6'd1);
      send(1'b1, 6'd0);   // cursor to row 1 so clear's home is visible
      for (int c = 0; c < 32; c++) push(8'hFF, 5'(c), 6'h3F);
      send(1'b1, 6'd2);
      cnt = 0;
      while (busy && cnt < 600) begin
         @(negedge clk);
         cnt++;
         if (cnt % 4 == 0) blank = ~blank;
      end
      chk("clear_timeout", int'(busy), 0);
      blank = 1'b1;
      @(negedge clk);
      #1;
      chk("clear_all_written", exp_q.size(), 0);
      chk("clear_cursor_row", int'(cursor_row), 0);
      chk("clear_cursor_col", int'(cursor_col), 0);

      // ---- reset during clear at sweep column 10
      send(1'b1, 6'd0);   // cursor row 1
      for (int c = 0; c < 10; c++) push(8'hFF, 5'(c), 6'h3F);
      send(1'b1, 6'd2);
      cnt = 0;
      while (exp_q.size() != 0 && cnt < 100) begin
         @(negedge clk);
         #1;
         cnt++;
      end
      chk("partial_clear_strobes", exp_q.size(), 0);
      rst_n = 1'b0;
      #1;
      chk("async_rst_row_en", int'(wr_row_en), 0);
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_in_ready", int'(bus.in_ready), 1);
      chk("async_rst_wr_col", int'(wr_col), 0);
      chk("async_rst_wr_char", int'(wr_char), 0);
      chk("async_rst_cursor", int'({cursor_row, cursor_col}), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("post_rst_busy", int'(busy), 0);
      chk("final_queue_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_char_write_ctrl
`default_nettype wire
